// File: rtl/ibuffer_warp_replay_q.sv
// Per-warp instruction buffer: DEPTH-entry circular queue with in-order issue and LW/SW replay tracking.
// Optional IBUF_FLUSH_EN adds a flush input that discards every entry not yet issued.
module ibuffer_warp_replay_q #(
    parameter int unsigned NUM_THREADS = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PAYLOAD_W   = 96,
    parameter int unsigned SCBID_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef IBUF_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic [1:0]             if_inflight,
    output logic                   req_if,
    input  logic                   enq_valid,
    input  logic                   enq_drop,
    input  logic [PAYLOAD_W-1:0]   enq_payload,
    input  logic [NUM_THREADS-1:0] enq_am,
    input  logic                   enq_mem,
    input  logic                   enq_exit,
    input  logic                   enq_dst_valid,
    output logic                   iss_req,
    input  logic                   iss_grt,
    output logic                   iss_is_replay,
    output logic [PAYLOAD_W-1:0]   iss_payload,
    output logic [NUM_THREADS-1:0] iss_am,
    output logic [SCBID_W-1:0]     iss_scbid,
    input  logic                   oc_full,
    input  logic                   alloc_stall,
    input  logic                   scb_full,
    input  logic                   scb_dependent,
    input  logic                   scb_empty,
    input  logic [SCBID_W-1:0]     scb_id_in,
    output logic                   scb_alloc,
    output logic                   scb_replayable,
    output logic                   scb_dst_valid,
    output logic                   rpl_done,
    output logic [SCBID_W-1:0]     rpl_done_scbid,
    input  logic                   posfb_valid,
    input  logic [NUM_THREADS-1:0] posfb_mask,
    input  logic                   zerofb_valid,
    output logic                   exit_req,
    input  logic                   exit_grt,
    output logic                   ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = PW + 2;

    logic [PW-1:0]          wp_q, rp_q, irp_q;
    logic [PW-1:0]          wp_d, rp_d, irp_d;
    logic [PW-1:0]          rp_next, occ, flush_span;
    logic [AW-1:0]          wi, ri, ii, si;
    logic [DEPTH-1:0]       valid_q, valid_d, replay_q, replay_d;
    logic [DEPTH-1:0]       exit_q, mem_q, dst_q, flush_clr;
    logic [PAYLOAD_W-1:0]   payload_q [DEPTH];
    logic [NUM_THREADS-1:0] pam_q     [DEPTH];
    logic [SCBID_W-1:0]     scbid_q   [DEPTH];
    logic [NUM_THREADS-1:0] pam_next;
    logic [CW-1:0]          fetch_sum;
    logic                   ovf_q, ovf_d;
    logic                   full, enq_try, enq, do_flush;
    logic                   has_rp, rp_valid, issued_pending, fb_live, fb_apply;
    logic                   retire, rpl_set, norm_ok, sel_replay, req_raw;
    logic                   exit_take, grant, norm_grant, rpl_grant;

`ifdef IBUF_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign wi  = wp_q[AW-1:0];
    assign ri  = rp_q[AW-1:0];
    assign ii  = irp_q[AW-1:0];
    assign occ = wp_q - irp_q;

    assign full    = (occ == PW'(DEPTH));
    assign enq_try = enq_valid & ~enq_drop;
    assign enq     = enq_try & ~full & ~do_flush;

    assign fetch_sum = CW'(occ) + CW'(if_inflight) + CW'(enq_valid);
    assign req_if    = (fetch_sum < CW'(DEPTH));

    // RP == WP means nothing is left to issue, even though entry[RP] may alias a pending IRP entry.
    assign has_rp   = (rp_q != wp_q);
    assign rp_valid = has_rp & valid_q[ri];

    // MEM feedback only belongs to an entry at IRP that has already been issued.
    assign issued_pending = (rp_q != irp_q);
    assign fb_live        = issued_pending & valid_q[ii];
    assign fb_apply       = posfb_valid & fb_live;
    assign pam_next       = fb_apply ? (pam_q[ii] & ~posfb_mask) : pam_q[ii];
    assign retire         = fb_live & (pam_next == '0);
    assign rpl_set        = fb_live & (zerofb_valid | (posfb_valid & (pam_next != '0)));

    assign norm_ok = rp_valid & ~exit_q[ri] & ~scb_full & ~scb_dependent & ~oc_full & ~alloc_stall;

    // Replay from IRP has priority; a younger mem op may not pass a pending replay.
    always_comb begin
        sel_replay = 1'b0;
        req_raw    = 1'b0;
        if (!fb_live) begin
            req_raw = norm_ok;
        end else if (replay_q[ii] | zerofb_valid | (posfb_valid & (pam_next != '0))) begin
            sel_replay = 1'b1;
            req_raw    = ~oc_full;
        end else if (rp_valid & ~replay_q[ri]) begin
            req_raw = norm_ok;
        end
    end

    assign exit_req   = rp_valid & exit_q[ri] & scb_empty;
    assign exit_take  = exit_req & exit_grt;
    assign iss_req    = req_raw & ~exit_take;
    assign grant      = iss_req & iss_grt;
    assign norm_grant = grant & ~sel_replay;
    assign rpl_grant  = grant & sel_replay;
    assign rp_next    = rp_q + PW'(norm_grant | exit_take);

    assign si             = sel_replay ? ii : ri;
    assign iss_is_replay  = sel_replay;
    assign iss_payload    = payload_q[si];
    assign iss_am         = pam_q[si];
    assign iss_scbid      = scbid_q[si];
    assign scb_alloc      = norm_grant;
    assign scb_replayable = mem_q[ri];
    assign scb_dst_valid  = dst_q[ri];
    assign rpl_done       = retire;
    assign rpl_done_scbid = scbid_q[ii];
    assign ovf_err        = ovf_q;

    // Entries in [RP_next, WP) are the unissued ones a flush discards.
    assign flush_span = wp_q - rp_next;
    always_comb begin
        flush_clr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            flush_clr[i] = (PW'(AW'(AW'(i) - rp_next[AW-1:0])) < flush_span);
        end
    end

    // Next-state for pointers, valid/replay bits and the overflow flag.
    always_comb begin
        valid_d  = valid_q;
        replay_d = replay_q;
        if (enq) begin
            valid_d[wi]  = 1'b1;
            replay_d[wi] = enq_mem;
        end
        if (norm_grant) begin
            replay_d[ri] = 1'b0;
            if (!mem_q[ri]) begin
                valid_d[ri] = 1'b0;
            end
        end
        if (exit_take) begin
            valid_d[ri] = 1'b0;
        end
        if (rpl_grant) begin
            replay_d[ii] = 1'b0;
        end
        if (rpl_set) begin
            replay_d[ii] = 1'b1;
        end
        if (retire) begin
            valid_d[ii]  = 1'b0;
            replay_d[ii] = 1'b0;
        end
        if (do_flush) begin
            valid_d = valid_d & ~flush_clr;
        end
        wp_d  = do_flush ? rp_next : (wp_q + PW'(enq));
        rp_d  = rp_next;
        irp_d = valid_d[ii] ? irp_q : rp_next;
        ovf_d = ovf_q | (enq_try & full & ~do_flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            irp_q    <= '0;
            valid_q  <= '0;
            replay_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            irp_q    <= irp_d;
            valid_q  <= valid_d;
            replay_q <= replay_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry payload storage; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (enq) begin
            payload_q[wi] <= enq_payload;
            pam_q[wi]     <= enq_am;
            exit_q[wi]    <= enq_exit;
            mem_q[wi]     <= enq_mem;
            dst_q[wi]     <= enq_dst_valid;
        end
        if (fb_apply) begin
            pam_q[ii] <= pam_next;
        end
        if (norm_grant) begin
            scbid_q[ri] <= scb_id_in;
        end
    end

endmodule
